// File: rtl/seven_seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared segment encodings and scan state type for the
//                seven-segment scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Scan phases: dark gap between digits, then one digit lit.
    typedef enum logic [0:0] {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_ctrl_if
//  Description : Load/display bundle between a value producer (master) and
//                the scan controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_done;

    modport master (
        output load, value, blank_lz,
        input  seg, dig_en, frame_done
    );

    modport slave (
        input  load, value, blank_lz,
        output seg, dig_en, frame_done
    );
endinterface : seven_seg_scan_ctrl_if
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_bcd_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_decode
//  Description : Combinational BCD to seven-segment decoder; non-decimal
//                codes 10-15 produce a dark digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_decode
    import seven_seg_pkg::*;
(
    input  wire logic [3:0] i_bcd,
    output logic      [6:0] o_seg
);

    // Table lookup; anything outside 0-9 is shown dark.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule : bcd_seg_decode
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_ctrl
//  Description : Time-multiplexed N-digit seven-segment scan controller with
//                dark inter-digit gaps, leading-zero blanking and a
//                double-buffered value applied only at frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 500
) (
    input  wire logic            clk,
    input  wire logic            rst,
    seven_seg_scan_ctrl_if.slave bus
);

    localparam int c_cnt_max = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW        = $clog2(c_cnt_max);
    localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW        = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] c_show_last = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] c_gap_last  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] c_idx_last  = IW'(NUM_DIGITS - 1);

    scan_state_t           r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig_en;
    logic                  r_frame_done;

    logic [VW-1:0]         r_shadow_val;
    logic                  r_shadow_blank;
    logic                  r_pending;
    logic [VW-1:0]         r_disp_val;
    logic                  r_disp_blank;

    logic                  w_boundary;
    logic [NUM_DIGITS-1:0] w_lz_mask;
    logic                  w_all_zero;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [3:0]            w_digit;
    logic                  w_digit_blank;
    logic [6:0]            w_dec_seg;
    logic [6:0]            w_slot_seg;

    // The last digit's slot ending is the only point where display may change.
    assign w_boundary = (r_state == SHOW) && (r_cnt == c_show_last) && (r_idx == c_idx_last);

    // Leading-zero mask: walk down from the MSD while digits stay zero; digit 0 never blanks.
    always_comb begin
        w_lz_mask  = '0;
        w_all_zero = r_disp_blank;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_all_zero   = w_all_zero && (r_disp_val[4*i +: 4] == 4'd0);
            w_lz_mask[i] = w_all_zero;
        end
    end

    // Select the current digit, its blank flag and its enable bit.
    always_comb begin
        w_digit       = 4'd0;
        w_digit_blank = 1'b0;
        w_onehot      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_digit       = r_disp_val[4*i +: 4];
                w_digit_blank = w_lz_mask[i];
                w_onehot[i]   = 1'b1;
            end
        end
    end

    bcd_seg_decode u_decode (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    assign w_slot_seg = w_digit_blank ? SEG_BLANK : w_dec_seg;

    // Scan FSM: alternates GAP and SHOW, advancing the digit index after each SHOW.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= GAP;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_seg        <= SEG_BLANK;
            r_dig_en     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_state  <= SHOW;
                        r_cnt    <= '0;
                        r_dig_en <= w_onehot;
                        r_seg    <= w_slot_seg;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SHOW: begin
                    if (r_cnt == c_show_last) begin
                        r_state      <= GAP;
                        r_cnt        <= '0;
                        r_dig_en     <= '0;
                        r_seg        <= SEG_BLANK;
                        r_frame_done <= (r_idx == c_idx_last);
                        r_idx        <= (r_idx == c_idx_last) ? '0 : r_idx + IW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= GAP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Double buffer: loads land in the shadow, promoted to display at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_val   <= '0;
            r_shadow_blank <= 1'b0;
            r_pending      <= 1'b0;
            r_disp_val     <= '0;
            r_disp_blank   <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_disp_val   <= r_shadow_val;
                r_disp_blank <= r_shadow_blank;
            end
            if (bus.load) begin
                r_shadow_val   <= bus.value;
                r_shadow_blank <= bus.blank_lz;
                r_pending      <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dig_en     = r_dig_en;
    assign bus.frame_done = r_frame_done;

endmodule : seven_seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_ctrl
//  Description : Directed self-checking bench for seven_seg_scan_ctrl with
//                NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=2 (24-cycle frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam logic [6:0] c_s0 = 7'b1111110;
    localparam logic [6:0] c_s1 = 7'b0110000;
    localparam logic [6:0] c_s2 = 7'b1101101;
    localparam logic [6:0] c_s3 = 7'b1111001;
    localparam logic [6:0] c_s4 = 7'b0110011;
    localparam logic [6:0] c_s5 = 7'b1011011;
    localparam logic [6:0] c_s7 = 7'b1110000;
    localparam logic [6:0] c_s9 = 7'b1111011;
    localparam logic [6:0] c_sx = 7'b0000000;

    logic clk;
    logic rst;
    int   edge_n;
    int   checks;
    int   errors;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic go(input int e);
        while (edge_n < e) step();
    endtask

    // Present a load strobe so that it is sampled on edge e.
    task automatic do_load(input int e, input logic [15:0] v, input logic blz);
        go(e - 1);
        bus.load     = 1'b1;
        bus.value    = v;
        bus.blank_lz = blz;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [6:0] es, input logic [3:0] ed, input logic efd);
        checks++;
        assert (bus.seg === es && bus.dig_en === ed && bus.frame_done === efd)
        else begin
            errors++;
            $error("FAIL %s edge %0d: seg=%b dig_en=%b frame_done=%b, expected seg=%b dig_en=%b frame_done=%b",
                   tag, edge_n, bus.seg, bus.dig_en, bus.frame_done, es, ed, efd);
        end
    endtask

    // Directed sequence; frame f occupies edges 24f+1..24f+24, digit d lit after edge 24f+6d+2.
    initial begin
        checks       = 0;
        errors       = 0;
        edge_n       = 0;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.blank_lz = 1'b0;

        step(); step(); step();
        chk("reset", c_sx, 4'b0000, 1'b0);
        rst    = 1'b0;
        edge_n = 0;

        // Frame 0: idle display of 0000, load 1234 mid-frame.
        go(1);  chk("f0_gap_e1",  c_sx, 4'b0000, 1'b0);
        go(2);  chk("f0_d0_e2",   c_s0, 4'b0001, 1'b0);
        do_load(5, 16'h1234, 1'b0);
                chk("f0_d0_e5",   c_s0, 4'b0001, 1'b0);
        go(6);  chk("f0_gap_e6",  c_sx, 4'b0000, 1'b0);
        go(7);  chk("f0_gap_e7",  c_sx, 4'b0000, 1'b0);
        go(8);  chk("f0_d1",      c_s0, 4'b0010, 1'b0);
        go(14); chk("f0_d2",      c_s0, 4'b0100, 1'b0);
        go(20); chk("f0_d3_old",  c_s0, 4'b1000, 1'b0);
        go(23); chk("f0_pre_bnd", c_s0, 4'b1000, 1'b0);
        go(24); chk("f0_bnd",     c_sx, 4'b0000, 1'b1);
        go(25); chk("f0_post",    c_sx, 4'b0000, 1'b0);

        // Frame 1: 1234 visible; queue 0070 with leading-zero blanking.
        go(26); chk("f1_d0_4",    c_s4, 4'b0001, 1'b0);
        do_load(30, 16'h0070, 1'b1);
        go(32); chk("f1_d1_3",    c_s3, 4'b0010, 1'b0);
        go(44); chk("f1_d3_1",    c_s1, 4'b1000, 1'b0);

        // Frame 2: 0070 blanked to "  70".
        go(50); chk("f2_d0_0",    c_s0, 4'b0001, 1'b0);
        go(56); chk("f2_d1_7",    c_s7, 4'b0010, 1'b0);
        go(62); chk("f2_d2_blk",  c_sx, 4'b0100, 1'b0);
        go(68); chk("f2_d3_blk",  c_sx, 4'b1000, 1'b0);
        go(72); chk("f2_bnd",     c_sx, 4'b0000, 1'b1);

        // Frame 3: back-to-back loads, display still 0070.
        do_load(82, 16'h1111, 1'b0);
        go(86); chk("f3_d2_keep", c_sx, 4'b0100, 1'b0);
        do_load(92, 16'h2222, 1'b0);

        // Frame 4: only 2222 shown; queue 9999.
        go(98);  chk("f4_d0_2",   c_s2, 4'b0001, 1'b0);
        go(104); chk("f4_d1_2",   c_s2, 4'b0010, 1'b0);
        do_load(110, 16'h9999, 1'b0);
        go(116); chk("f4_d3_2",   c_s2, 4'b1000, 1'b0);

        // Load 5555 on boundary edge 120 while 9999 pending.
        do_load(120, 16'h5555, 1'b0);
                 chk("f4_bnd",    c_sx, 4'b0000, 1'b1);
        go(122); chk("f5_d0_9",   c_s9, 4'b0001, 1'b0);
        go(140); chk("f5_d3_9",   c_s9, 4'b1000, 1'b0);
        go(144); chk("f5_bnd",    c_sx, 4'b0000, 1'b1);
        go(146); chk("f6_d0_5",   c_s5, 4'b0001, 1'b0);
        do_load(150, 16'h00AF, 1'b0);
        go(164); chk("f6_d3_5",   c_s5, 4'b1000, 1'b0);

        // Frame 7: 00AF, non-decimal codes dark with enables asserted, no blanking.
        go(170); chk("f7_d0_F",   c_sx, 4'b0001, 1'b0);
        go(176); chk("f7_d1_A",   c_sx, 4'b0010, 1'b0);
        go(182); chk("f7_d2_0",   c_s0, 4'b0100, 1'b0);
        go(188); chk("f7_d3_0",   c_s0, 4'b1000, 1'b0);

        // Frame 8: queue 8888 then reset mid-SHOW of digit 2.
        do_load(195, 16'h8888, 1'b0);
        go(206); chk("f8_d2_0",   c_s0, 4'b0100, 1'b0);
        rst = 1'b1;
        step();  chk("mid_reset", c_sx, 4'b0000, 1'b0);
        rst    = 1'b0;
        edge_n = 0;

        // After release: display 0000, pending 8888 discarded.
        go(1);  chk("r_gap_e1",  c_sx, 4'b0000, 1'b0);
        go(2);  chk("r_d0_e2",   c_s0, 4'b0001, 1'b0);
        go(24); chk("r_bnd",     c_sx, 4'b0000, 1'b1);
        go(26); chk("r_f1_d0",   c_s0, 4'b0001, 1'b0);
        go(44); chk("r_f1_d3",   c_s0, 4'b1000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seven_seg_scan_ctrl
`default_nettype wire
